// File: rtl/penguronik_sum_decoder_pkg.sv
// Shared types and sizing for the bit-serial sum decoder.
package penguronik_pkg;

    localparam int DEC_WIDTH = 8;
    localparam int DEC_CNT_W = $clog2(DEC_WIDTH) + 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_HOLD
    } dec_state_t;

endpackage

// File: rtl/penguronik_sum_decoder_if.sv
// Operand and result handshake bundle between a source/consumer (master) and the decoder (slave).
interface penguronik_sum_decoder_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] sum_in;
    logic [WIDTH-1:0] addend_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff_out;
    logic             borrow_out;
    logic [WIDTH-1:0] diff_oe;

    modport master (
        output in_valid, sum_in, addend_in, out_ready,
        input  in_ready, out_valid, diff_out, borrow_out, diff_oe
    );

    modport slave (
        input  in_valid, sum_in, addend_in, out_ready,
        output in_ready, out_valid, diff_out, borrow_out, diff_oe
    );
endinterface

// File: rtl/penguronik_sum_decoder_fsub1.sv
// Combinational 1-bit full subtractor: d = a - b - bin, bout set on underflow.
module penguronik_fsub1 (
    input  logic a_i,
    input  logic b_i,
    input  logic bin_i,
    output logic d_o,
    output logic bout_o
);
    assign d_o    = a_i ^ b_i ^ bin_i;
    assign bout_o = (~a_i & b_i) | (~(a_i ^ b_i) & bin_i);
endmodule

// File: rtl/penguronik_sum_decoder.sv
// Bit-serial decoder recovering A = S - B mod 2^WIDTH plus borrow, LSB first, one bit per enabled clock.
// Result valid WIDTH enabled cycles after accept; held in HOLD until out_ready, no same-cycle turnaround.
module penguronik_sum_decoder
    import penguronik_pkg::*;
#(
    parameter int WIDTH = DEC_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ena,
    penguronik_sum_decoder_if.slave bus
);
    localparam int               CNT_W    = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    dec_state_t       state_q, state_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic             br_q, br_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic dbit;
    logic bout;

    penguronik_fsub1 u_fsub (
        .a_i    (s_q[0]),
        .b_i    (b_q[0]),
        .bin_i  (br_q),
        .d_o    (dbit),
        .bout_o (bout)
    );

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        b_d     = b_q;
        d_d     = d_q;
        br_d    = br_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    s_d     = bus.sum_in;
                    b_d     = bus.addend_in;
                    d_d     = '0;
                    br_d    = 1'b0;
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                // difference bits enter at the MSB so the LSB lands at bit 0 after WIDTH shifts
                d_d   = {dbit, d_q[WIDTH-1:1]};
                br_d  = bout;
                s_d   = s_q >> 1;
                b_d   = b_q >> 1;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (bus.out_ready) begin
                    d_d     = '0;
                    br_d    = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            s_q     <= '0;
            b_q     <= '0;
            d_q     <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
        end else if (ena) begin
            state_q <= state_d;
            s_q     <= s_d;
            b_q     <= b_d;
            d_q     <= d_d;
            br_q    <= br_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs are masked outside HOLD so a partially shifted result is never visible.
    assign bus.in_ready   = (state_q == ST_IDLE);
    assign bus.out_valid  = (state_q == ST_HOLD);
    assign bus.diff_out   = bus.out_valid ? d_q : '0;
    assign bus.borrow_out = bus.out_valid & br_q;
    assign bus.diff_oe    = {WIDTH{bus.out_valid}};
endmodule

// File: tb/tb_penguronik_sum_decoder.sv
// Directed and randomized round-trip checks of the sum decoder against arithmetic expectations.
module tb_penguronik_sum_decoder;
    localparam int W = 8;

    logic clk;
    logic rst;
    logic ena;
    int   checks;
    int   errors;

    penguronik_sum_decoder_if #(.WIDTH(W)) bus ();

    penguronik_sum_decoder #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .ena (ena),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Present an operand pair and return just after the accepting edge.
    task automatic send(input logic [W-1:0] s, input logic [W-1:0] b);
        int n;
        bus.sum_in    = s;
        bus.addend_in = b;
        bus.in_valid  = 1'b1;
        n = 0;
        while (bus.in_ready !== 1'b1 && n < 50) begin
            step();
            n++;
        end
        if (n >= 50) chk("in_ready_timeout", 32'd0, 32'd1);
        step();
        bus.in_valid = 1'b0;
    endtask

    // Count edges until out_valid is seen.
    task automatic wait_out(output int edges);
        edges = 0;
        while (bus.out_valid !== 1'b1 && edges < 100) begin
            step();
            edges++;
        end
        if (edges >= 100) chk("out_valid_timeout", 32'd0, 32'd1);
    endtask

    task automatic check_result(input string tag, input logic [W-1:0] s, input logic [W-1:0] b);
        logic [W-1:0] exp_d;
        logic         exp_b;
        exp_d = W'((int'(s) - int'(b) + 256) % 256);
        exp_b = (int'(s) < int'(b));
        chk({tag, "_diff"}, 32'(bus.diff_out), 32'(exp_d));
        chk({tag, "_borrow"}, 32'(bus.borrow_out), 32'(exp_b));
    endtask

    initial begin
        int edges;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] s;
        logic         exp_borrow;

        checks        = 0;
        errors        = 0;
        rst           = 1'b1;
        ena           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.sum_in    = '0;
        bus.addend_in = '0;
        bus.out_ready = 1'b1;
        step();
        step();
        rst = 1'b0;

        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_diff", 32'(bus.diff_out), 32'd0);
        chk("rst_borrow", 32'(bus.borrow_out), 32'd0);
        chk("rst_oe", 32'(bus.diff_oe), 32'd0);

        // 200 - 55: counting the accept edge as edge 1, out_valid appears after edge W+1
        send(8'd200, 8'd55);
        wait_out(edges);
        chk("lat_basic", 32'(edges), 32'(W));
        check_result("basic", 8'd200, 8'd55);
        chk("basic_oe", 32'(bus.diff_oe), 32'hFF);
        chk("basic_in_ready_hold", 32'(bus.in_ready), 32'd0);
        step();
        chk("basic_oe_drop", 32'(bus.diff_oe), 32'd0);
        chk("basic_valid_drop", 32'(bus.out_valid), 32'd0);
        chk("basic_in_ready_back", 32'(bus.in_ready), 32'd1);

        send(8'd10, 8'd20);   wait_out(edges); check_result("s10_b20", 8'd10, 8'd20); step();
        send(8'd0, 8'd0);     wait_out(edges); check_result("s0_b0", 8'd0, 8'd0); step();
        send(8'd0, 8'd255);   wait_out(edges); check_result("s0_b255", 8'd0, 8'd255); step();

        // Backpressure with a competing operand presented while holding
        bus.out_ready = 1'b0;
        send(8'd10, 8'd20);
        wait_out(edges);
        bus.sum_in    = 8'd77;
        bus.addend_in = 8'd3;
        bus.in_valid  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check_result("bp", 8'd10, 8'd20);
            chk("bp_valid", 32'(bus.out_valid), 32'd1);
            chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
            step();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        step();
        chk("bp_release", 32'(bus.out_valid), 32'd0);

        // Reset during the fourth shift cycle aborts the operation
        send(8'd50, 8'd7);
        step();
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort_valid", 32'(bus.out_valid), 32'd0);
        chk("abort_oe", 32'(bus.diff_oe), 32'd0);
        chk("abort_in_ready", 32'(bus.in_ready), 32'd1);
        send(8'd100, 8'd1);
        wait_out(edges);
        chk("post_abort_lat", 32'(edges), 32'(W));
        check_result("post_abort", 8'd100, 8'd1);
        step();

        // Three frozen cycles mid-shift add exactly three edges of latency
        send(8'd123, 8'd45);
        step();
        step();
        ena = 1'b0;
        step();
        step();
        step();
        ena = 1'b1;
        wait_out(edges);
        chk("ena_lat", 32'(edges + 5), 32'(W + 3));
        check_result("ena", 8'd123, 8'd45);
        step();

        // Round trip: random A, B; decode of (A+B) mod 256 must give A back
        bus.out_ready = 1'b0;
        for (int k = 0; k < 1000; k++) begin
            a = W'($urandom_range(0, 255));
            b = W'($urandom_range(0, 255));
            s = W'((int'(a) + int'(b)) % 256);
            exp_borrow = (int'(a) + int'(b)) > 255;
            send(s, b);
            wait_out(edges);
            chk("rt_diff", 32'(bus.diff_out), 32'(a));
            chk("rt_borrow", 32'(bus.borrow_out), 32'(exp_borrow));
            bus.sum_in    = W'($urandom);
            bus.addend_in = W'($urandom);
            bus.in_valid  = 1'b1;
            for (int j = 0; j < int'($urandom_range(0, 2)); j++) step();
            bus.out_ready = 1'b1;
            step();
            bus.out_ready = 1'b0;
        end
        bus.in_valid = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
